// File: rtl/sd_pkg.sv
// sd_pkg: shared state encoding, MCU command codes and channel/image limits for the SD request front-end.
package sd_pkg;
    localparam int NCH_MAX = 8;
    localparam int NIMG_MAX = 8;
    typedef enum logic [1:0] {ST_IDLE, ST_ANNOUNCE, ST_SD_IO} state_t;
    localparam logic [7:0] SDC_STATUS = 8'd1;
    localparam logic [7:0] SDC_GO = 8'd2;
    localparam logic [7:0] SDC_INSERTED = 8'd4;
    localparam logic [7:0] SDC_REJECT = 8'd6;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: picks the first pending channel after last, searching upward with wrap.
module rr_arbiter #(
    parameter int NCH = 4,
    parameter int CHW = 2
) (
    input  logic [NCH-1:0] pend,
    input  logic [CHW-1:0] last,
    output logic [CHW-1:0] grant,
    output logic           any
);
    always_comb begin
        any = |pend;
        grant = '0;
        for (int k = NCH; k >= 1; k--)
            grant = pend[(int'(last) + k) % NCH] ? CHW'((int'(last) + k) % NCH) : grant;
    end
endmodule

// File: rtl/sd_req_arbiter.sv
// sd_req_arbiter: latches per-channel sector requests, grants round-robin and runs the MCU announce/translate handshake.
module sd_req_arbiter
    import sd_pkg::*;
#(
    parameter int NCH = 4,
    parameter int NIMG = 4,
    parameter int CHW = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              data_strobe,
    input  logic              data_start,
    input  logic [7:0]        data_in,
    output logic [7:0]        data_out,
    output logic              irq,
    input  logic              iack,
    input  logic [NCH-1:0]    req_rd,
    input  logic [NCH-1:0]    req_wr,
    input  logic [NCH*32-1:0] req_sector,
    output logic [NCH-1:0]    ch_done,
    output logic [NCH-1:0]    ch_err,
    input  logic [3:0]        card_stat,
    input  logic [1:0]        card_type,
    output logic              sd_rstart,
    output logic              sd_wstart,
    output logic [31:0]       sd_sector,
    input  logic              sd_busy,
    input  logic              sd_done,
    output logic [CHW-1:0]    grant,
    output logic              grant_valid,
    output logic [31:0]       image_size,
    output logic [NIMG-1:0]   image_mounted
);
    state_t state;
    logic [NCH-1:0] req_q, pend, dir, clr, req_edge;
    logic [31:0] sec [NCH];
    logic [31:0] sec_g;
    logic [CHW-1:0] last, arb_grant;
    logic arb_any, rej, fin;
    logic [7:0] cmd, target, stat_byte;
    logic [3:0] cnt;

    rr_arbiter #(.NCH(NCH), .CHW(CHW)) u_rr (
        .pend(pend), .last(last), .grant(arb_grant), .any(arb_any)
    );

    always_comb begin
        req_edge = (req_rd | req_wr) & ~req_q;
        rej = state == ST_ANNOUNCE && data_strobe && data_start && data_in == SDC_REJECT;
        fin = state == ST_SD_IO && sd_done;
        clr = (rej || fin) ? NCH'(1) << grant : '0;
        sec_g = sec[grant];
        stat_byte = cnt == 4'd0 ? {dir[grant], 4'd0, 3'(grant)} :
                    cnt == 4'd1 ? sec_g[31:24] :
                    cnt == 4'd2 ? sec_g[23:16] :
                    cnt == 4'd3 ? sec_g[15:8] :
                    cnt == 4'd4 ? sec_g[7:0] : 8'h00;
    end

    // a new edge on a channel that is being retired this cycle re-pends it
    always_ff @(posedge clk) begin
        if (reset) begin
            req_q <= '0;
            pend <= '0;
            dir <= '0;
            for (int i = 0; i < NCH; i++) sec[i] <= '0;
        end else begin
            req_q <= req_rd | req_wr;
            for (int i = 0; i < NCH; i++) begin
                if (req_edge[i] && (!pend[i] || clr[i])) begin
                    pend[i] <= 1'b1;
                    dir[i] <= req_wr[i];
                    sec[i] <= req_sector[32*i +: 32];
                end else if (clr[i]) begin
                    pend[i] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
            last <= CHW'(NCH - 1);
            grant <= '0;
            grant_valid <= 1'b0;
            irq <= 1'b0;
            cmd <= '0;
            cnt <= '0;
            target <= '0;
            data_out <= '0;
            sd_rstart <= 1'b0;
            sd_wstart <= 1'b0;
            sd_sector <= '0;
            ch_done <= '0;
            ch_err <= '0;
            image_size <= '0;
            image_mounted <= '0;
        end else begin
            ch_done <= '0;
            ch_err <= '0;
            image_mounted <= '0;
            if (iack) irq <= 1'b0;
            if (state == ST_IDLE && arb_any) begin
                grant <= arb_grant;
                grant_valid <= 1'b1;
                irq <= 1'b1;
                state <= ST_ANNOUNCE;
            end
            if (rej || fin) begin
                ch_done <= clr;
                ch_err <= rej ? clr : '0;
                last <= grant;
                grant_valid <= 1'b0;
                sd_rstart <= 1'b0;
                sd_wstart <= 1'b0;
                state <= ST_IDLE;
            end
            if (data_strobe && data_start) begin
                cmd <= data_in;
                cnt <= '0;
                data_out <= {card_stat, card_type, sd_busy, grant_valid};
            end else if (data_strobe) begin
                cnt <= cnt + {3'd0, cnt != 4'hf};
                if (cmd == SDC_STATUS) data_out <= stat_byte;
                if (cmd == SDC_GO) begin
                    data_out <= cnt < 4'd4 ? 8'hff : {7'd0, state == ST_SD_IO};
                    if (state == ST_ANNOUNCE && cnt < 4'd4) begin
                        sd_sector <= {sd_sector[23:0], data_in};
                        if (cnt == 4'd3) begin
                            sd_wstart <= dir[grant];
                            sd_rstart <= !dir[grant];
                            state <= ST_SD_IO;
                        end
                    end
                end
                if (cmd == SDC_INSERTED) begin
                    if (cnt == 4'd0) target <= data_in;
                    else if (cnt < 4'd5) image_size <= {image_size[23:0], data_in};
                    if (cnt == 4'd4 && 32'(target) < NIMG) image_mounted <= NIMG'(1) << target;
                end
            end
        end
    end
endmodule

// File: doc/sd_req_arbiter.md
# sd_req_arbiter

Parametrised request front-end between up to eight core-side sector requesters and the single `sd_rw` engine. It latches per-channel read/write requests and arbitrates them round-robin. Each granted request is announced to the MCU over the byte-strobe interface; the MCU returns a translated physical sector, and the block then drives `sd_rw` and returns a per-channel completion pulse. It replaces the fixed four-source request handling in the SD wrapper and adds queued pending requests, fair arbitration, and an MCU reject path.

## Interface
- `NCH`, 4: requester channels, 1..8
- `NIMG`, 4: mountable images, 1..8
- `CHW`, max(1,$clog2(NCH)): channel index width (derived)

Ports:
- `clk` in 1: sole clock
- `reset` in 1: synchronous, active-high
- `data_strobe`, `data_start` in 1: MCU byte strobe; first byte of a command
- `data_in` in 8, `data_out` out 8: MCU byte data
- `irq` out 1, `iack` in 1: MCU interrupt; acknowledge
- `req_rd`, `req_wr` in NCH: per-channel request levels
- `req_sector` in NCH*32: channel i sector at [32i+31:32i]
- `ch_done` out NCH: one-cycle completion pulse
- `ch_err` out NCH: valid with `ch_done`; 1 = MCU rejected
- `card_stat` in 4, `card_type` in 2: from `sd_rw`
- `sd_rstart`, `sd_wstart` out 1: level to `sd_rw`, held until `sd_done`
- `sd_sector` out 32: translated sector
- `sd_busy`, `sd_done` in 1: from `sd_rw`
- `grant` out CHW, `grant_valid` out 1: owning channel, for data-path muxing
- `image_size` out 32, `image_mounted` out NIMG: image report; `image_mounted` is a one-cycle pulse

## Operation
- Request capture: a rising edge of `req_rd[i]|req_wr[i]` sets `pend[i]`, stores `dir[i]` (1 = write if `req_wr[i]`) and `sec[i]`. An edge on a channel whose `pend[i]` is already set is ignored; there is no per-channel queueing.
- States: IDLE, ANNOUNCE, SD_IO.
- IDLE:
  - If any `pend` is set, grant the first set channel searching from `last+1` mod NCH, upward with wrap.
  - Set `grant`, `grant_valid`=1, `irq`=1, go to ANNOUNCE.
- MCU command byte (`data_start`): latch the command, set byte count to 0, `data_out`={card_stat, card_type, sd_busy, grant_valid}.
- Cmd 1 STATUS: reads return, in order:
  - {dir, 4'd0, grant zero-extended to 3 bits}
  - `sec[grant]` MSB first, 4 bytes
- Cmd 2 GO (ANNOUNCE only; ignored elsewhere):
  - 4 bytes MSB first go to `sd_sector`.
  - On the 4th byte, assert `sd_wstart` if `dir`=1, else `sd_rstart`, and go to SD_IO.
  - Reads return 0xFF for bytes 0-3, then {7'd0, in SD_IO}.
- Cmd 6 REJECT (ANNOUNCE only): on the command byte, pulse `ch_done[grant]` and `ch_err[grant]`, clear `pend[grant]`, set `last`=`grant`, go to IDLE.
- SD_IO: on `sd_done`, drop `sd_rstart`/`sd_wstart`, pulse `ch_done[grant]` with `ch_err`=0, clear `pend`, set `last`=`grant`, drop `grant_valid`, go to IDLE.
- Cmd 4 INSERTED:
  - Byte 0 is the target; bytes 1-4 are `image_size`, MSB first.
  - On byte 4, pulse `image_mounted[target]` if target<NIMG.
- Unknown commands: no effect; `data_out` holds its value. The byte count saturates at 15.

## Timing
- Reset values: all outputs 0, state IDLE, `last`=NCH-1 (so channel 0 wins first), `pend`=0, `image_size`=0.
- Request edge to `grant_valid`/`irq`: 2 cycles (edge capture, then arbitration).
- `irq` rises on entry to ANNOUNCE and is cleared by `iack`. If a raise and `iack` occur in the same cycle, the raise wins.
- `data_out` is registered and is valid on the cycle after the strobe.
- 4th GO byte to `sd_*start` high: 1 cycle.
- `sd_done` to `ch_done` pulse: 1 cycle. The next grant comes no earlier than 1 cycle after that.
- A request edge on a channel in the same cycle its `pend` clears wins: the channel re-pends and the done pulse is still emitted.
- `reset` mid-transfer drops `sd_*start` and emits no `ch_done`.

## Structure
- Shared package `sd_pkg`: state encoding, command codes (`SDC_STATUS`=1, `SDC_GO`=2, `SDC_INSERTED`=4, `SDC_REJECT`=6), `NCH`/`NIMG` limits.
- One sub-module, `rr_arbiter` (NCH): inputs `pend`, `last`; outputs `grant`, `any`.

## Test plan
- Reset, then pulse `req_rd[0]` with sector 0x00001234 → `grant`=0 and `irq`=1 after 2 cycles; STATUS returns 0x00, 0x00, 0x00, 0x12, 0x34.
- GO with 0xDEADBEEF → `sd_rstart`=1, `sd_sector`=0xDEADBEEF; `sd_done` → `ch_done[0]`=1, `ch_err`=0 one cycle later.
- Requests on channels 1, 2 and 3 in the same cycle with `last`=1 → grant order 2, 3, 1.
- `req_wr[2]` then REJECT → `ch_done[2]`=`ch_err[2]`=1, `sd_wstart` never asserted.
- INSERTED with target 1, size 0x000B4000 → `image_size`=0x000B4000, `image_mounted`=4'b0010 for one cycle; target 9 → no pulse.
- Assert `reset` during SD_IO → all outputs 0 next cycle; a fresh request is serviced normally.
